// File: rtl/color_menu_ctrl_if.sv
// Button-side and driver-side signals of the colour selection menu.
// The bench side is master; the controller side is slave.
interface color_menu_ctrl_if;
  logic       en;
  logic       btn_next;
  logic       btn_prev;
  logic       btn_sel;
  logic [3:0] cmode_colorch;
  logic       cmode_btn0;
  logic [3:0] confirmed_color;
  logic       menu_active;

  modport master (
    output en, btn_next, btn_prev, btn_sel,
    input  cmode_colorch, cmode_btn0, confirmed_color, menu_active
  );

  modport slave (
    input  en, btn_next, btn_prev, btn_sel,
    output cmode_colorch, cmode_btn0, confirmed_color, menu_active
  );
endinterface

// File: rtl/color_menu_ctrl.sv
// Colour menu front end for the RGB PWM driver: debounces next/prev/select,
// browses a wrapping colour index with auto-repeat and emits a confirm strobe.
//
// state   | meaning
// IDLE    | menu disabled, outputs held, edges ignored
// BROWSE  | index follows next/prev edges and auto-repeat
// CONFIRM | one-cycle confirm strobe on cmode_btn0
module color_menu_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_COLORS      = 13,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic              clk,
  input  logic              nrst,
  color_menu_ctrl_if.slave  bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [3:0]    LAST_IDX   = 4'(NUM_COLORS - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RPT_FIRE   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  typedef enum logic [1:0] {IDLE, BROWSE, CONFIRM} state_t;

  state_t        state;
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [2:0]    deb_q;
  logic [2:0]    rise;
  logic [DW-1:0] deb_cnt [3];
  logic [RW-1:0] hold_cnt;
  logic          hold_on;
  logic          rpt_fire;
  logic          next_e;
  logic          prev_e;
  logic          sel_e;
  logic          step_up;
  logic          step_dn;
  logic [3:0]    colorch;
  logic [3:0]    confirmed;
  logic          strobe;
  logic          active;

  // bit 0 = next, bit 1 = prev, bit 2 = select
  assign raw = {bus.btn_sel, bus.btn_prev, bus.btn_next};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_q <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      deb <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          deb[i]     <= ~deb[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise   = deb & ~deb_q;
  assign next_e = rise[0];
  assign prev_e = rise[1];
  assign sel_e  = rise[2];

  // Hold timer runs only while exactly one direction is held in BROWSE.
  assign hold_on  = (state == BROWSE) && bus.en && (deb[0] ^ deb[1]);
  assign rpt_fire = hold_on && (hold_cnt == RPT_FIRE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hold_cnt <= '0;
    end else if (!hold_on) begin
      hold_cnt <= '0;
    end else if (rpt_fire) begin
      hold_cnt <= RPT_RELOAD;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign step_up = (next_e & ~prev_e) | (rpt_fire & deb[0]);
  assign step_dn = (prev_e & ~next_e) | (rpt_fire & deb[1]);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      colorch   <= '0;
      confirmed <= '0;
      strobe    <= 1'b0;
      active    <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (!bus.en) begin
        state  <= IDLE;
        active <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= BROWSE;
            active  <= 1'b1;
            colorch <= '0;
          end
          BROWSE: begin
            // Select outranks any direction step arriving in the same cycle.
            if (sel_e) begin
              state     <= CONFIRM;
              strobe    <= 1'b1;
              confirmed <= colorch;
            end else if (step_up) begin
              colorch <= (colorch == LAST_IDX) ? 4'd0 : colorch + 4'd1;
            end else if (step_dn) begin
              colorch <= (colorch == 4'd0) ? LAST_IDX : colorch - 4'd1;
            end
          end
          CONFIRM: begin
            state <= BROWSE;
          end
          default: begin
            state  <= IDLE;
            active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.cmode_colorch   = colorch;
  assign bus.cmode_btn0      = strobe;
  assign bus.confirmed_color = confirmed;
  assign bus.menu_active     = active;

endmodule

// File: tb/tb_color_menu_ctrl.sv
// Randomised bench for color_menu_ctrl: presses are turned into expected index
// steps and strobes by a press-level model; a monitor scores the DUT outputs.
module tb_color_menu_ctrl;

  localparam int DEB = 4;
  localparam int NC  = 13;
  localparam int RD  = 20;
  localparam int RP  = 8;

  logic clk  = 1'b0;
  logic nrst = 1'b1;

  color_menu_ctrl_if bus ();

  color_menu_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .NUM_COLORS      (NC),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int idx_q[$];
  int strobe_q[$];
  int idx = 0;
  logic [3:0] last_color = 4'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every index change and every strobe consumes one expectation.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (bus.cmode_colorch !== last_color) begin
        if (idx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_index_change: got %0d, no change expected (was %0d)",
                   bus.cmode_colorch, last_color);
        end else begin
          e = idx_q.pop_front();
          chk("index_step", int'(bus.cmode_colorch), e);
        end
        chk("index_in_range", int'(bus.cmode_colorch < 4'(NC)), 1);
        last_color = bus.cmode_colorch;
      end
      if (bus.cmode_btn0 === 1'b1) begin
        if (strobe_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got strobe with index %0d, none expected",
                   bus.cmode_colorch);
        end else begin
          e = strobe_q.pop_front();
          chk("strobe_index", int'(bus.cmode_colorch), e);
          chk("strobe_confirmed", int'(bus.confirmed_color), e);
        end
      end
    end
  end

  // Debounced level is high for exactly len cycles once len >= DEB; the edge
  // gives one step, repeat adds one at RD held cycles and every RP after.
  task automatic press(input bit nx, input bit pv, input bit sl, input int len);
    int n;
    n = 0;
    if (len >= DEB) begin
      if (sl) begin
        strobe_q.push_back(idx);
      end else if (nx != pv) begin
        n = 1;
        if (len >= RD) n += 1 + (len - RD) / RP;
        for (int k = 0; k < n; k++) begin
          idx = nx ? (idx + 1) % NC : (idx + NC - 1) % NC;
          idx_q.push_back(idx);
        end
      end
    end
    @(posedge clk);
    #1;
    bus.btn_next = nx;
    bus.btn_prev = pv;
    bus.btn_sel  = sl;
    repeat (len) @(posedge clk);
    #1;
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    bus.btn_sel  = 1'b0;
    repeat (14) @(posedge clk);
  endtask

  task automatic drain(input string name);
    #1;
    chk({name, "_steps_pending"}, idx_q.size(), 0);
    chk({name, "_strobes_pending"}, strobe_q.size(), 0);
    chk({name, "_index"}, int'(bus.cmode_colorch), idx);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_colorch"}, int'(bus.cmode_colorch), 0);
    chk({name, "_btn0"}, int'(bus.cmode_btn0), 0);
    chk({name, "_confirmed"}, int'(bus.confirmed_color), 0);
    chk({name, "_active"}, int'(bus.menu_active), 0);
  endtask

  initial begin
    int t;
    int r;
    bus.en       = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    bus.btn_sel  = 1'b0;
    #2 nrst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_active", int'(bus.menu_active), 0);

    bus.en = 1'b1;
    @(negedge clk);
    chk("enable_active", int'(bus.menu_active), 1);
    chk("enable_colorch", int'(bus.cmode_colorch), 0);
    chk("enable_btn0", int'(bus.cmode_btn0), 0);

    press(1, 0, 0, 3);  drain("glitch");
    press(1, 0, 0, 10); drain("single_next");

    press(0, 1, 0, 8);
    press(0, 1, 0, 8);  drain("prev_wrap");
    press(1, 0, 0, 8);  drain("next_wrap");
    press(0, 1, 0, 8);  drain("prev_wrap2");

    for (int i = 0; i < 6; i++) press(1, 0, 0, 6);
    drain("to_five");
    press(0, 0, 1, 8);  drain("sel_five");
    chk("confirmed_five", int'(bus.confirmed_color), 5);

    for (int i = 0; i < 5; i++) press(0, 1, 0, 6);
    drain("to_zero");
    press(1, 0, 0, 60); drain("auto_repeat");
    chk("auto_repeat_index", int'(bus.cmode_colorch), 7);

    for (int i = 0; i < 4; i++) press(0, 1, 0, 6);
    drain("to_three");
    press(1, 0, 1, 6);  drain("sel_with_next");
    press(1, 1, 0, 30); drain("both_dirs");

    // Drop en while the strobe is up.
    strobe_q.push_back(idx);
    @(posedge clk);
    #1 bus.btn_sel = 1'b1;
    t = 0;
    while (bus.cmode_btn0 !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("confirm_reached", int'(bus.cmode_btn0), 1);
    bus.en = 1'b0;
    @(negedge clk);
    chk("en_drop_btn0", int'(bus.cmode_btn0), 0);
    chk("en_drop_active", int'(bus.menu_active), 0);
    chk("en_drop_colorch", int'(bus.cmode_colorch), idx);
    chk("en_drop_confirmed", int'(bus.confirmed_color), idx);
    bus.btn_sel = 1'b0;
    repeat (12) @(negedge clk);
    chk("en_low_active", int'(bus.menu_active), 0);
    chk("en_low_colorch", int'(bus.cmode_colorch), idx);

    if (idx != 0) idx_q.push_back(0);
    idx = 0;
    bus.en = 1'b1;
    @(negedge clk);
    chk("reenable_active", int'(bus.menu_active), 1);
    drain("reenable");

    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)       press(1, 0, 0, int'($urandom_range(1, 45)));
      else if (r < 8)  press(0, 1, 0, int'($urandom_range(1, 45)));
      else if (r == 8) press(0, 0, 1, int'($urandom_range(1, 10)));
      else             press(1, 1, 0, int'($urandom_range(1, 30)));
    end
    drain("random");

    // Reset in the middle of a select press: no strobe may follow.
    press(1, 0, 0, 8);
    drain("pre_reset");
    if (idx != 0) idx_q.push_back(0);
    idx = 0;
    @(posedge clk);
    #1 bus.btn_sel = 1'b1;
    repeat (4) @(posedge clk);
    #1 nrst = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_reset");
    bus.btn_sel = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_active", int'(bus.menu_active), 1);
    drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/color_menu_ctrl.md
Name: color_menu_ctrl

Overview:
Front-end selection controller for the RGB PWM LED driver. It debounces the next, previous and select push-buttons and maintains a browsed colour index in the range 0..NUM_COLORS-1. On select it issues the one-cycle confirm strobe with the index that the driver consumes on its colour-select inputs. It sits between the board buttons and the RGB driver, and drives that driver's cmode_colorch and cmode_btn0.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a debounced level changes (10 ms at 100 MHz)
NUM_COLORS, 13, number of selectable colours; index wraps within 0..NUM_COLORS-1
REPEAT_DELAY, 50000000, cycles a direction button must be held before auto-repeat starts
REPEAT_PERIOD, 20000000, cycles between auto-repeat steps once repeating

Ports:
clk  input  1  system clock, 100 MHz
nrst  input  1  asynchronous active-low reset
en  input  1  menu enable, same signal as the driver's en
btn_next  input  1  raw button, step index up
btn_prev  input  1  raw button, step index down
btn_sel  input  1  raw button, confirm current index
cmode_colorch  output  4  browsed colour index, to driver
cmode_btn0  output  1  one-cycle confirm strobe, to driver
confirmed_color  output  4  last confirmed index, for display/debug
menu_active  output  1  high while in BROWSE or CONFIRM

Behaviour:
- Reset (nrst low, asynchronous):
  - state=IDLE
  - cmode_colorch=0, confirmed_color=0
  - cmode_btn0=0, menu_active=0
  - all synchronisers, debounce counters and repeat counters cleared; debounced levels=0.
- Input conditioning:
  - Each raw button passes through a 2-flop synchroniser.
  - The debounced level flips only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears that button's counter.
  - Rising edge = debounced high AND previous debounced low.
- States:
  - IDLE: outputs held; edges ignored. On en=1, go to BROWSE and load cmode_colorch=0 (maroon, matching the driver's enable default).
  - BROWSE: menu_active=1.
    - Next edge: index+1; NUM_COLORS-1 wraps to 0.
    - Prev edge: index-1; 0 wraps to NUM_COLORS-1.
    - The index updates on the cycle after the edge.
    - Sel edge: go to CONFIRM.
  - CONFIRM: lasts exactly one cycle.
    - cmode_btn0=1; confirmed_color<=cmode_colorch.
    - Then return to BROWSE; cmode_btn0 returns to 0 the following cycle.
- Priority within one cycle: sel > (next XOR prev).
  - Next and prev edges in the same cycle: no step.
  - Sel with a direction edge: confirm the unstepped index; discard the step.
- Auto-repeat:
  - While exactly one of next/prev is debounced-high in BROWSE, a hold counter runs.
  - At REPEAT_DELAY cycles, one step fires; further steps fire every REPEAT_PERIOD cycles.
  - Release, or both buttons held, clears the counter.
  - Sel never repeats; one press gives one strobe.
- en falls (any state, including CONFIRM):
  - Go to IDLE next cycle; cmode_btn0 forced 0.
  - cmode_colorch and confirmed_color retain their values.
  - Hold counters cleared.
- Index width: 4 bits; values >= NUM_COLORS never appear on cmode_colorch.
- Mid-operation reset: immediate return to reset values; no strobe is emitted.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
1. Reset, then en=1 -> cmode_colorch=0, menu_active=1, cmode_btn0=0.
2. Glitch btn_next high for 3 cycles -> no index change. Hold 10 cycles -> index 0→1 exactly once.
3. From index 12, press next -> 0. Press prev -> 12.
4. Index 5, press sel -> cmode_btn0 high for exactly 1 cycle with cmode_colorch=5; confirmed_color=5.
5. Hold btn_next 60 cycles from index 0 -> 1 step at the debounced edge, a step at hold count 20, then steps every 8 cycles.
6. Sel and next edges in the same cycle at index 3 -> strobe with 3, index stays 3. Deassert en during CONFIRM -> strobe cut, state IDLE, index retained.
